fp_accum_framer: RTL and testbench
==================================

// Module: fp_accum_framer
// PURPOSE
//  Upstream framer for floating_point_accumulate. Accepts a vector-length command and a
//  valid/ready element stream, and emits the valid/start/last/data stream the accumulator
//  consumes. Zero-pads each vector to a multiple of PAD_MULT elements. The accumulator
//  pairs samples at every tree stage, so an element count that is not a multiple of
//  PAD_MULT would pair across vector boundaries.
// PARAMETERS
//  FRAC_WIDTH  24  fraction width incl. sign, same meaning as in the accumulator
//  EXP_WIDTH    8  exponent width; DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH
//  LEN_WIDTH   16  command length width; max vector length 2^LEN_WIDTH-1
//  PAD_MULT    16  padding granule; power of two, = 2^NUM_STAGES of the accumulator
// PORTS
//  clkIn        in   1           clock
//  rstNIn       in   1           asynchronous active-low reset
//  cmdValidIn   in   1           command valid
//  cmdReadyOut  out  1           command ready (high only in IDLE)
//  cmdLenIn     in   LEN_WIDTH   elements in vector; 0 allowed
//  sValidIn     in   1           element valid
//  sReadyOut    out  1           element ready (high only in STREAM)
//  sDataIn      in   DATA_WIDTH  element value
//  validOut     out  1           to accumulator validIn
//  startOut     out  1           to accumulator startIn; first beat of a vector
//  lastOut      out  1           to accumulator lastIn; final (padded) beat of a vector
//  dataOut      out  DATA_WIDTH  to accumulator dataIn
//  busyOut      out  1           state != IDLE
//  vecCountOut  out  16          vectors fully emitted; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; validOut, startOut, lastOut = 0;
//    dataOut = 0; vecCountOut = 0; counters = 0. cmdReadyOut = 1 after reset.
//    sReadyOut = 0 after reset.
//  - cmdReadyOut = (state==IDLE) and sReadyOut = (state==STREAM). Both decode the state
//    register only, with no combinational path from any input.
//  - Lengths: len = cmdLenIn; padLen = ceil(len/PAD_MULT)*PAD_MULT, computed LEN_WIDTH+1
//    wide, no overflow. len==0 gives padLen = PAD_MULT.
//  - FSM:
//    IDLE: on cmdValidIn&&cmdReadyOut latch len and padLen, clear beat count.
//      Next state is STREAM if len!=0, else PAD.
//    STREAM: each sValidIn&&sReadyOut is one beat; beat count += 1.
//      On the beat where count reaches len: go to IDLE if len==padLen, else PAD.
//    PAD: emits one zero beat (data = all zeros, i.e. +0.0) every cycle,
//      with no dependency on inputs. Go to IDLE on the beat where count reaches padLen.
//  - Output beats are registered, latency 1 cycle from acceptance (or from a PAD cycle).
//    Per beat: validOut=1; dataOut = element or 0; startOut=1 only on beat 1;
//    lastOut=1 only on beat padLen. In non-beat cycles validOut, startOut, lastOut = 0
//    and dataOut holds its last value.
//  - len==0 vector: PAD_MULT zero beats, start on the first, last on the last.
//  - Gaps: sValidIn low in STREAM produces output bubbles and all counters hold.
//    The accumulator tolerates bubbles. There is no backpressure from the accumulator.
//  - vecCountOut increments in the cycle the lastOut beat is driven.
//  - Back-to-back: the final beat returns the FSM to IDLE. The next command is accepted
//    the following cycle, giving a minimum 1-cycle bubble between vectors.
//  - cmdValidIn while busy is ignored (not accepted). sValidIn outside STREAM is not
//    accepted.
//  - Reset mid-vector drops the partial vector and leaves no pending beats.
//    The accumulator must be reset in the same window; top-level owns this.
// TESTING
//  1. len=16, elements 1.0 (0x3F800000) back-to-back -> 16 beats at t+1..t+16,
//     start on beat 1, last on beat 16, no pad, vecCount=1.
//  2. len=5, values 1.0..5.0 -> 5 data beats then 11 zero beats. Last on beat 16;
//     accumulator result = 15.0 (0x41700000).
//  3. len=0 -> 16 zero beats with start and last; sReadyOut never high;
//     accumulator result = 0.0.
//  4. len=17 with sValidIn toggling every other cycle -> bubbles mirrored,
//     17 data beats + 15 pad beats, last on beat 32.
//  5. Two commands queued (len=16 then len=3) -> second accepted 1 cycle after first
//     IDLE. Exactly one start per vector; vecCount=2.
//  6. Assert rstNIn low at beat 7 of len=16 -> outputs 0 asynchronously.
//     After release: cmdReadyOut=1, vecCount=0, and a fresh len=16 command
//     completes normally.

Source files
------------

// File: rtl/fp_accum_framer.sv
// rtl/fp_accum_framer.sv - command/stream framer that zero-pads vectors for floating_point_accumulate
// One command per vector; elements pass through with 1-cycle latency, then PAD_MULT-aligned zero fill.
module fp_accum_framer #(
  parameter int FRAC_WIDTH = 24,
  parameter int EXP_WIDTH  = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int PAD_MULT   = 16,
  localparam int DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH
) (
  input  logic                  clkIn,
  input  logic                  rstNIn,
  input  logic                  cmdValidIn,
  output logic                  cmdReadyOut,
  input  logic [LEN_WIDTH-1:0]  cmdLenIn,
  input  logic                  sValidIn,
  output logic                  sReadyOut,
  input  logic [DATA_WIDTH-1:0] sDataIn,
  output logic                  validOut,
  output logic                  startOut,
  output logic                  lastOut,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  busyOut,
  output logic [15:0]           vecCountOut
);

  localparam int PAD_LOG = $clog2(PAD_MULT);
  localparam logic [LEN_WIDTH:0] CNT_ONE  = (LEN_WIDTH+1)'(1);
  localparam logic [LEN_WIDTH:0] PAD_FULL = (LEN_WIDTH+1)'(PAD_MULT);
  localparam logic [LEN_WIDTH:0] PAD_RND  = (LEN_WIDTH+1)'(PAD_MULT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_PAD    = 2'd2
  } state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH:0]    r_pad_len;
  logic [LEN_WIDTH:0]    r_cnt;
  logic                  r_valid;
  logic                  r_start;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_data;
  logic [15:0]           r_vec_count;

  logic [LEN_WIDTH:0]    w_len_ext;
  logic [LEN_WIDTH:0]    w_round;
  logic [LEN_WIDTH:0]    w_pad_len;
  logic [LEN_WIDTH:0]    w_cnt_inc;
  logic                  w_first;
  logic                  w_final;

  // Round up to the granule one bit wider than the length so 2^LEN_WIDTH-1 cannot overflow.
  assign w_len_ext = {1'b0, cmdLenIn};
  assign w_round   = w_len_ext + PAD_RND;
  assign w_pad_len = (cmdLenIn == '0) ? PAD_FULL
                                      : {w_round[LEN_WIDTH:PAD_LOG], {PAD_LOG{1'b0}}};

  assign w_cnt_inc = r_cnt + CNT_ONE;
  assign w_first   = (r_cnt == '0);
  assign w_final   = (w_cnt_inc == r_pad_len);

  assign cmdReadyOut = (r_state == S_IDLE);
  assign sReadyOut   = (r_state == S_STREAM);
  assign busyOut     = (r_state != S_IDLE);
  assign validOut    = r_valid;
  assign startOut    = r_start;
  assign lastOut     = r_last;
  assign dataOut     = r_data;
  assign vecCountOut = r_vec_count;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_pad_len   <= '0;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
      r_start     <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= '0;
      r_vec_count <= '0;
    end else begin
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_last  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmdValidIn) begin
            r_len     <= cmdLenIn;
            r_pad_len <= w_pad_len;
            r_cnt     <= '0;
            r_state   <= (cmdLenIn != '0) ? S_STREAM : S_PAD;
          end
        end
        S_STREAM: begin
          if (sValidIn) begin
            r_cnt   <= w_cnt_inc;
            r_valid <= 1'b1;
            r_data  <= sDataIn;
            r_start <= w_first;
            r_last  <= w_final;
            if (w_final) begin
              r_vec_count <= r_vec_count + 16'd1;
            end
            if (w_cnt_inc == {1'b0, r_len}) begin
              r_state <= ({1'b0, r_len} == r_pad_len) ? S_IDLE : S_PAD;
            end
          end
        end
        S_PAD: begin
          // Zero fill (+0.0) runs free of the input stream.
          r_cnt   <= w_cnt_inc;
          r_valid <= 1'b1;
          r_data  <= '0;
          r_start <= w_first;
          r_last  <= w_final;
          if (w_final) begin
            r_vec_count <= r_vec_count + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_framer.sv
// tb/tb_fp_accum_framer.sv - randomized bench for fp_accum_framer against a beat-queue model
module tb_fp_accum_framer;

  logic        clkIn = 1'b0;
  logic        rstNIn;
  logic        cmdValidIn;
  logic        cmdReadyOut;
  logic [15:0] cmdLenIn;
  logic        sValidIn;
  logic        sReadyOut;
  logic [31:0] sDataIn;
  logic        validOut;
  logic        startOut;
  logic        lastOut;
  logic [31:0] dataOut;
  logic        busyOut;
  logic [15:0] vecCountOut;

  always #5 clkIn = ~clkIn;

  fp_accum_framer dut (
    .clkIn       (clkIn),
    .rstNIn      (rstNIn),
    .cmdValidIn  (cmdValidIn),
    .cmdReadyOut (cmdReadyOut),
    .cmdLenIn    (cmdLenIn),
    .sValidIn    (sValidIn),
    .sReadyOut   (sReadyOut),
    .sDataIn     (sDataIn),
    .validOut    (validOut),
    .startOut    (startOut),
    .lastOut     (lastOut),
    .dataOut     (dataOut),
    .busyOut     (busyOut),
    .vecCountOut (vecCountOut)
  );

  typedef struct {
    logic [31:0] data;
    bit          pad;
    bit          start;
    bit          last;
  } beat_t;

  beat_t       q[$];
  logic [31:0] vec_data[$];
  logic [31:0] obs_data[$];
  logic [31:0] ftab[5];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          obs_len = 0;
  int          obs_gap = 0;
  int          last_last_cyc = 0;
  bit          accepted = 0;
  bit          tog = 0;
  logic        exp_valid = 0;
  logic        exp_start = 0;
  logic        exp_last = 0;
  logic [31:0] exp_data = 0;
  logic [15:0] exp_vec = 0;

  function automatic int pad_len_of(input int len);
    if (len == 0) return 16;
    return ((len + 15) / 16) * 16;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A vector is simply its full list of output beats: elements, then zeros up to the padded length.
  task automatic build(input int len);
    beat_t b;
    int    pl;
    pl = pad_len_of(len);
    for (int i = 0; i < pl; i++) begin
      b.pad   = (i >= len);
      b.data  = (!b.pad && i < vec_data.size()) ? vec_data[i] : 32'h0;
      b.start = (i == 0);
      b.last  = (i == pl - 1);
      q.push_back(b);
    end
  endtask

  task automatic compare();
    chk("valid",     64'(validOut),    64'(exp_valid));
    chk("start",     64'(startOut),    64'(exp_start));
    chk("last",      64'(lastOut),     64'(exp_last));
    chk("data",      64'(dataOut),     64'(exp_data));
    chk("vec_count", 64'(vecCountOut), 64'(exp_vec));
    chk("cmd_ready", 64'(cmdReadyOut), 64'(q.size() == 0));
    chk("s_ready",   64'(sReadyOut),   64'(q.size() > 0 && !q[0].pad));
    chk("busy",      64'(busyOut),     64'(q.size() > 0));
    if (validOut === 1'b1) begin
      if (startOut === 1'b1) begin
        obs_data.delete();
        obs_gap = cyc - last_last_cyc;
      end
      obs_data.push_back(dataOut);
      if (lastOut === 1'b1) begin
        last_last_cyc = cyc;
        obs_len = obs_data.size();
      end
    end
  endtask

  task automatic step();
    beat_t b;
    @(posedge clkIn);
    cyc++;
    if (!rstNIn) begin
      q.delete();
      exp_valid = 0; exp_start = 0; exp_last = 0; exp_data = 0; exp_vec = 0;
    end else begin
      exp_valid = 0; exp_start = 0; exp_last = 0;
      if (q.size() == 0) begin
        if (cmdValidIn) begin
          build(int'(cmdLenIn));
          accepted = 1;
        end
      end else if (q[0].pad || sValidIn) begin
        b = q.pop_front();
        exp_valid = 1;
        exp_data  = b.data;
        exp_start = b.start;
        exp_last  = b.last;
        if (b.last) exp_vec++;
      end
    end
    #1;
    compare();
  endtask

  task automatic drive_s(input int gmode);
    if (q.size() > 0 && !q[0].pad) begin
      tog = ~tog;
      case (gmode)
        0:       sValidIn = 1'b1;
        1:       sValidIn = tog;
        default: sValidIn = 1'($urandom_range(0, 1));
      endcase
      sDataIn = sValidIn ? q[0].data : $urandom;
    end else begin
      sValidIn = 1'($urandom_range(0, 1));
      sDataIn  = $urandom;
    end
  endtask

  task automatic idle(input int n);
    cmdValidIn = 0;
    for (int i = 0; i < n; i++) begin
      drive_s(2);
      step();
    end
  endtask

  task automatic run_vector(input int len, input int dmode, input int gmode);
    int n;
    vec_data.delete();
    for (int i = 0; i < len; i++) begin
      case (dmode)
        0:       vec_data.push_back(32'h3F800000);
        1:       vec_data.push_back(ftab[i % 5]);
        default: vec_data.push_back($urandom);
      endcase
    end
    cmdValidIn = 1;
    cmdLenIn   = 16'(len);
    drive_s(2);
    accepted = 0;
    n = 0;
    while (!accepted && n < 50) begin
      step();
      n++;
    end
    if (!accepted) chk("accept_timeout", 64'(0), 64'(1));
    n = 0;
    while (q.size() > 0 && n < 5000) begin
      cmdValidIn = 1'($urandom_range(0, 1));
      cmdLenIn   = 16'($urandom);
      drive_s(gmode);
      step();
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'(0));
    cmdValidIn = 0;
  endtask

  initial begin
    logic [31:0] acc;
    int          len;
    int          r;
    ftab[0] = 32'h3F800000; ftab[1] = 32'h40000000; ftab[2] = 32'h40400000;
    ftab[3] = 32'h40800000; ftab[4] = 32'h40A00000;
    rstNIn = 0; cmdValidIn = 0; cmdLenIn = 0; sValidIn = 0; sDataIn = 0;
    step();
    step();
    rstNIn = 1;
    chk("rst_vec",       64'(vecCountOut), 64'(0));
    chk("rst_cmd_ready", 64'(cmdReadyOut), 64'(1));
    chk("rst_s_ready",   64'(sReadyOut),   64'(0));
    chk("rst_valid",     64'(validOut),    64'(0));

    chk("padlen_0",     64'(pad_len_of(0)),     64'(16));
    chk("padlen_5",     64'(pad_len_of(5)),     64'(16));
    chk("padlen_16",    64'(pad_len_of(16)),    64'(16));
    chk("padlen_17",    64'(pad_len_of(17)),    64'(32));
    chk("padlen_65535", 64'(pad_len_of(65535)), 64'(65536));

    run_vector(16, 0, 0);
    chk("t1_vec",    64'(vecCountOut), 64'(1));
    chk("t1_len",    64'(obs_len),     64'(16));
    chk("t1_beat16", 64'(obs_data[15]), 64'(32'h3F800000));
    idle(2);

    run_vector(5, 1, 0);
    chk("t2_len",    64'(obs_len),      64'(16));
    chk("t2_beat5",  64'(obs_data[4]),  64'(32'h40A00000));
    chk("t2_beat6",  64'(obs_data[5]),  64'(0));
    chk("t2_beat16", 64'(obs_data[15]), 64'(0));
    chk("t2_vec",    64'(vecCountOut),  64'(2));
    idle(1);

    run_vector(0, 0, 0);
    acc = 0;
    foreach (obs_data[i]) acc = acc | obs_data[i];
    chk("t3_len",  64'(obs_len),     64'(16));
    chk("t3_zero", 64'(acc),         64'(0));
    chk("t3_vec",  64'(vecCountOut), 64'(3));
    idle(3);

    run_vector(17, 2, 1);
    chk("t4_len",    64'(obs_len),      64'(32));
    chk("t4_beat18", 64'(obs_data[17]), 64'(0));
    chk("t4_vec",    64'(vecCountOut),  64'(4));

    run_vector(16, 0, 0);
    run_vector(3, 2, 0);
    chk("t5_gap", 64'(obs_gap),     64'(2));
    chk("t5_len", 64'(obs_len),     64'(16));
    chk("t5_vec", 64'(vecCountOut), 64'(6));

    for (int k = 0; k < 30; k++) begin
      idle($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r == 0)      len = 0;
      else if (r == 1) len = 16 * $urandom_range(1, 3);
      else if (r == 2) len = $urandom_range(100, 200);
      else             len = $urandom_range(1, 40);
      run_vector(len, 2, $urandom_range(0, 2));
    end

    idle(2);
    vec_data.delete();
    for (int i = 0; i < 16; i++) vec_data.push_back(32'h3F800000);
    cmdValidIn = 1;
    cmdLenIn   = 16;
    step();
    cmdValidIn = 0;
    sValidIn   = 1;
    sDataIn    = 32'h3F800000;
    repeat (7) step();
    chk("t6_beat7_valid", 64'(validOut),        64'(1));
    chk("t6_beat7_count", 64'(obs_data.size()), 64'(7));
    #2;
    rstNIn = 0;
    #1;
    chk("t6_async_valid", 64'(validOut),    64'(0));
    chk("t6_async_data",  64'(dataOut),     64'(0));
    chk("t6_async_vec",   64'(vecCountOut), 64'(0));
    chk("t6_async_ready", 64'(cmdReadyOut), 64'(1));
    chk("t6_async_busy",  64'(busyOut),     64'(0));
    sValidIn = 0;
    step();
    step();
    rstNIn = 1;
    chk("t6_post_vec", 64'(vecCountOut), 64'(0));
    run_vector(16, 0, 0);
    chk("t6_fresh_len", 64'(obs_len),     64'(16));
    chk("t6_fresh_vec", 64'(vecCountOut), 64'(1));
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
